// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
//   DATA_BITS  : payload bits per frame
//   IDLE_LEVEL : level of the serial line when no frame is being sent
//   tx_state_e : transmitter FSM encoding (also exported on the debug port)
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with single-cycle write and pop.
//   clk, rst   : clock, synchronous active-low reset (empties the FIFO)
//   wr, din    : write strobe and data; ignored while full
//   rd         : pop strobe; ignored while empty
//   dout       : head entry (valid whenever empty=0)
//   full/empty : registered status, updated the cycle after a write or pop
// Pointers carry one extra bit so that equal low bits with differing top
// bits means full, fully equal pointers means empty.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp, rp, wp_n, rp_n;
  logic             do_wr, do_rd;

  // A write at full is dropped even if a pop happens in the same cycle.
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;

  assign wp_n = wp + {{AW{1'b0}}, do_wr};
  assign rp_n = rp + {{AW{1'b0}}, do_rd};

  assign dout = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      wp    <= wp_n;
      rp    <= rp_n;
      empty <= (wp_n == rp_n);
      full  <= (wp_n[AW] != rp_n[AW]) && (wp_n[AW-1:0] == rp_n[AW-1:0]);
    end
  end

  // Storage needs no reset: entries are only read between write and pop.
  always_ff @(posedge clk) begin
    if (rst && do_wr) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tx_ctl.sv
// UART transmit controller: queues bytes in a FIFO and sends them as 8N1
// frames, one bit per baud strobe.
//   clk    : system clock, all logic on the rising edge
//   rst    : synchronous active-low reset; aborts any frame, empties the FIFO
//   bclk   : baud strobe, high for one clk cycle per bit period
//   din    : byte to queue
//   din_wr : write strobe; accepted when full=0
//   full   : FIFO holds FIFO_DEPTH bytes
//   tx     : registered serial output, idle high
//   busy   : frame on the line or bytes queued
//   state  : current FSM state, for observation only
// Input handshake: din is taken on every rising clk edge where din_wr=1 and
// full=0 (and rst=1); there is no back-pressure beyond full.
module tx_ctl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bclk,
  input  logic [7:0] din,
  input  logic       din_wr,
  output logic       full,
  output logic       tx,
  output logic       busy,
  output tx_state_e  state
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic [DATA_BITS-1:0] head;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           cnt;
  logic                 empty;
  logic                 pop;

  // A byte is taken from the FIFO only on a strobe that starts a frame,
  // either from IDLE or straight after a stop bit.
  assign pop  = bclk && !empty && (state == IDLE || state == STOP);
  assign busy = !(state == IDLE && empty);

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (din_wr),
    .din   (din),
    .rd    (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      tx    <= IDLE_LEVEL;
      shift <= '0;
      cnt   <= '0;
    end else if (bclk) begin
      case (state)
        IDLE: begin
          if (!empty) begin
            shift <= head;
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          state <= DATA;
          cnt   <= '0;
          tx    <= shift[0];
        end
        DATA: begin
          if (cnt == LAST_BIT) begin
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            shift <= shift >> 1;
            cnt   <= cnt + 3'd1;
            tx    <= shift[1];
          end
        end
        STOP: begin
          if (!empty) begin
            shift <= head;
            state <= START;
            tx    <= 1'b0;
          end else begin
            state <= IDLE;
            tx    <= IDLE_LEVEL;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule
